cla_nibble_seq_adder: RTL
=========================

Name: cla_nibble_seq_adder

Overview:
- Multi-cycle WIDTH-bit adder controller that time-shares one 4-bit carry-lookahead slice, one nibble per clock, LSB nibble first.
- A registered carry chains the nibble slices together.
- Start/busy/done handshake; result registers hold until the next accepted start.
- Sits between the lab's operand registers and display/compare logic; replaces a wide combinational adder where area matters more than latency.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 8.
- NIB, WIDTH/4, nibble count (localparam, not overridable).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when result is final.
- sum  output  WIDTH  registered result.
- cout  output  1  carry out of MSB.
- ovf  output  1  signed overflow = carry into MSB XOR cout.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; operand, carry and index registers cleared. Applies immediately, including mid-RUN; the partial result is discarded.
- States:
  - IDLE: start=1 -> capture a, b, cin into op_a, op_b, carry_r; idx=0; go to RUN. start=0 -> stay.
  - RUN: each cycle the slice gets G=op_a[idx]&op_b[idx], P=op_a[idx]^op_b[idx], Cin=carry_r. sum nibble idx <= P ^ {C[3:1],carry_r}; carry_r <= slice Cout; idx <= idx+1. When idx==NIB-1: also cout <= Cout, ovf <= C[3]^Cout, go to DONE. start is ignored in RUN.
  - DONE: done=1 for exactly this cycle. start=1 -> capture and go to RUN (back-to-back). Otherwise go to IDLE.
- Latency: start sampled at edge 0 -> busy high after edges 1..NIB -> done high in the cycle after edge NIB. WIDTH=16: done is visible 4 cycles after the start edge. Throughput with back-to-back starts: one result per NIB+1 cycles.
- sum, cout, ovf change only during RUN. They are stable from DONE until the RUN cycle after the next accepted start. Nibbles above idx keep their old value until overwritten.
- Arithmetic: modulo 2^WIDTH. {cout,sum} = a+b+cin exactly.
- idx width is clog2(NIB). idx does not wrap past NIB-1 because the state leaves RUN there.
- The slice is the team's 4-bit CLA logic unit (G/P/Cin in; C[3:1], Cout, group P/G out). Group P/G outputs are unused here.

Optional Feature:
- Macro CLA_SEQ_SUB_EN.
- Defined: adds input port sub (1 bit), captured with the operands on accepted start. When sub=1: op_b <= ~b, carry_r <= 1, cin ignored, so the result is a-b. cout=1 means no borrow. ovf is signed overflow of the subtraction.
- Undefined: no sub port; add only.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, start=0 for 10 cycles -> busy=0, done=0, sum=0x0000, cout=0, ovf=0 throughout.
- Basic add, WIDTH=16: a=0x1234, b=0x4321, cin=0, start 1 cycle -> busy 4 cycles, done pulse in cycle 5, sum=0x5555, cout=0, ovf=0.
- Full ripple across nibbles: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Back-to-back and ignored start:
  - start held high continuously with a=0x00FF, b=0x0F01 -> a result every 5 cycles, sum=0x1000.
  - Change a to 0x0001 while busy -> current result unchanged; the new value is used at the next DONE.
- Reset mid-operation: start a=0xAAAA, b=0x5555, cin=1; assert rst_n=0 two cycles after start -> outputs 0 asynchronously, state IDLE, no done pulse after release.
- With CLA_SEQ_SUB_EN: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0. Then sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.

Source files
------------

// File: rtl/cla_nibble_seq_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit carry-lookahead slice reused per nibble, LSB first.
// Optional subtract mode is enabled by defining CLA_SEQ_SUB_EN (adds the 'sub' input).
module cla_nibble_seq_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned IdxW = $clog2(NIB);
    localparam int unsigned OffW = IdxW + 2;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  op_a_q, op_b_q, sum_q;
    logic              carry_q, cout_q, ovf_q, busy_q, done_q;
    logic [IdxW-1:0]   idx_q;

    logic [WIDTH-1:0]  cap_b;
    logic              cap_c;
    logic [OffW-1:0]   off;
    logic [3:0]        g, p, c, nib_sum;
    logic              slice_cout;
    logic              last_nib;

    // Operand B and carry as they will be captured on an accepted start.
    always_comb begin
`ifdef CLA_SEQ_SUB_EN
        cap_b = sub ? ~b : b;
        cap_c = sub ? 1'b1 : cin;
`else
        cap_b = b;
        cap_c = cin;
`endif
    end

    assign off      = {idx_q, 2'b00};
    assign last_nib = (idx_q == IdxW'(NIB - 1));

    // 4-bit carry-lookahead slice; group P/G are not needed for chaining through carry_q.
    always_comb begin
        g    = op_a_q[off +: 4] & op_b_q[off +: 4];
        p    = op_a_q[off +: 4] ^ op_b_q[off +: 4];
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & carry_q);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
        slice_cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                   | (p[3] & p[2] & p[1] & p[0] & carry_q);
        nib_sum = p ^ c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_a_q  <= a;
                        op_b_q  <= cap_b;
                        carry_q <= cap_c;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    sum_q[off +: 4] <= nib_sum;
                    carry_q         <= slice_cout;
                    if (last_nib) begin
                        cout_q  <= slice_cout;
                        ovf_q   <= c[3] ^ slice_cout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + IdxW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
